// File: rtl/rns_dot_acc.sv
// rns_dot_acc: streaming RNS multiply-accumulate over four byte-wide residue
// channels (moduli 251/241/239/233). Each vector is a run of operand beats
// terminated by in_last; the block emits one packed per-channel dot product.
//
// Ports:
//   clk, rst           clock, async active-high reset
//   in_valid/in_ready  operand beat handshake; in_a/in_b packed residues,
//                      channel i in bits [8i+7:8i]; in_last ends the vector
//   out_valid/out_ready result handshake; out_rns packed dot product,
//                      out_count beats in that vector (saturating)
//   busy               a vector is in flight or a result is waiting

// One residue channel: S1 registers the reduced product, S2 folds it into
// the running sum with a single conditional subtract.
module rns_dot_lane #(
  parameter int unsigned MOD = 251
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic       ld,      // beat accepted: capture product
  input  logic       acc_en,  // S1 holds a product: accumulate it
  input  logic       clr,     // this product closes the vector
  output logic [7:0] sum      // acc + p reduced, valid while acc_en
);
  logic [15:0] prod;
  logic [7:0]  p, acc;
  logic [8:0]  s;

  assign prod = {8'd0, a} * {8'd0, b};
  assign s    = {1'b0, acc} + {1'b0, p};
  // Both terms are < MOD, so one subtract fully reduces.
  assign sum  = (s >= 9'(MOD)) ? 8'(s - 9'(MOD)) : s[7:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      p   <= '0;
      acc <= '0;
    end else begin
      // Operands may be non-canonical; the full mod handles that.
      if (ld)     p   <= 8'(prod % 16'(MOD));
      if (acc_en) acc <= clr ? 8'd0 : sum;
    end
  end
endmodule

module rns_dot_acc #(
  parameter int unsigned B0    = 251,
  parameter int unsigned B1    = 241,
  parameter int unsigned B2    = 239,
  parameter int unsigned B3    = 233,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_a,
  input  logic [31:0]      in_b,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_rns,
  output logic [CNT_W-1:0] out_count,
  output logic             busy
);
  localparam int NUM_LANES = 4;

  typedef enum logic [1:0] {ACC, DRAIN, HOLD} state_t;
  state_t state_q, state_d;

  logic                          in_fire, s1_vld, s1_last, fin;
  logic [CNT_W-1:0]              cnt, cnt_nxt;
  logic [NUM_LANES-1:0][7:0]     a_v, b_v, lane_sum;

  assign a_v     = in_a;
  assign b_v     = in_b;
  assign in_fire = in_valid & in_ready;
  assign fin     = s1_vld & s1_last;   // S2 is closing the vector this cycle
  assign cnt_nxt = (&cnt) ? cnt : cnt + 1'b1;

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    localparam int unsigned MOD = (i == 0) ? B0 : (i == 1) ? B1 : (i == 2) ? B2 : B3;
    rns_dot_lane #(.MOD(MOD)) u_lane (
      .clk    (clk),
      .rst    (rst),
      .a      (a_v[i]),
      .b      (b_v[i]),
      .ld     (in_fire),
      .acc_en (s1_vld),
      .clr    (fin),
      .sum    (lane_sum[i])
    );
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ACC;
      s1_vld    <= 1'b0;
      s1_last   <= 1'b0;
      cnt       <= '0;
      out_rns   <= '0;
      out_count <= '0;
    end else begin
      state_q <= state_d;
      s1_vld  <= in_fire;
      if (in_fire) s1_last <= in_last;
      if (s1_vld)  cnt     <= fin ? '0 : cnt_nxt;
      if (fin) begin
        out_rns   <= lane_sum;
        out_count <= cnt_nxt;
      end
    end
  end

  // Decoded from raw inputs rather than in_fire to keep in_ready out of its
  // own fan-in.
  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state_q)
      ACC: begin
        in_ready = 1'b1;
        if (in_valid && in_last) state_d = DRAIN;
      end
      DRAIN: if (fin) state_d = HOLD;
      HOLD: begin
        out_valid = 1'b1;
        if (out_ready) state_d = ACC;
      end
      default: state_d = ACC;
    endcase
  end

  assign busy = (state_q != ACC) | s1_vld | (cnt != '0);
endmodule

// File: tb/tb_rns_dot_acc.sv
module tb_rns_dot_acc;
  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready, in_last;
  logic [31:0] in_a, in_b;
  logic        out_valid, out_ready;
  logic [31:0] out_rns;
  logic [15:0] out_count;
  logic        busy;

  int total = 0;
  int bad   = 0;

  rns_dot_acc dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready), .out_rns(out_rns), .out_count(out_count),
    .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Offer one beat at the negedge, hold until accepted, drop valid after it.
  task automatic beat(input logic [31:0] a, input logic [31:0] b, input logic last);
    int n = 0;
    @(negedge clk);
    in_valid = 1'b1; in_a = a; in_b = b; in_last = last;
    while (in_ready !== 1'b1 && n < 100) begin @(negedge clk); n++; end
    if (n >= 100) chk("beat_timeout", 32'(n), 32'd0);
    @(posedge clk); #1;
    in_valid = 1'b0; in_last = 1'b0;
  endtask

  task automatic take(input string tag, input logic [31:0] exp_rns, input int exp_cnt, input int dly);
    int n = 0;
    while (out_valid !== 1'b1 && n < 200) begin @(negedge clk); n++; end
    if (n >= 200) chk({tag, "_timeout"}, 32'(n), 32'd0);
    chk({tag, "_rns"}, out_rns, exp_rns);
    chk({tag, "_cnt"}, 32'(out_count), 32'(exp_cnt));
    repeat (dly) @(negedge clk);
    @(negedge clk); out_ready = 1'b1;
    @(posedge clk); #1; out_ready = 1'b0;
    chk({tag, "_ovdrop"}, 32'(out_valid), 32'd0);
  endtask

  localparam int MODS [4] = '{251, 241, 239, 233};

  initial begin
    logic [31:0] hold_rns;
    logic [15:0] hold_cnt;
    int acc [4];
    int beats, vlen, nb;
    logic [31:0] ra, rb;

    rst = 1'b1; in_valid = 0; in_last = 0; in_a = 0; in_b = 0; out_ready = 0;
    #7;
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_rns", out_rns, 32'd0);
    chk("rst_out_count", 32'(out_count), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    @(negedge clk); rst = 1'b0;

    // 3*5 + 4*6 = 39 in every channel; result two edges into the pipe
    beat(32'h03030303, 32'h05050505, 1'b0);
    chk("t1_busy_mid", 32'(busy), 32'd1);
    beat(32'h04040404, 32'h06060606, 1'b1);
    chk("t1_ov_early", 32'(out_valid), 32'd0);
    chk("t1_in_ready_drain", 32'(in_ready), 32'd0);
    @(posedge clk); #1;
    chk("t1_ov_on_time", 32'(out_valid), 32'd1);
    take("t1", 32'h27272727, 2, 0);
    chk("t1_in_ready_after", 32'(in_ready), 32'd1);

    // (-1)*(-1) three times -> 3
    repeat (2) beat(32'hE8EEF0FA, 32'hE8EEF0FA, 1'b0);
    beat(32'hE8EEF0FA, 32'hE8EEF0FA, 1'b1);
    take("t2", 32'h03030303, 3, 1);

    // (-1)*2 twice -> -4 per modulus, then backpressure in HOLD
    beat(32'hE8EEF0FA, 32'h02020202, 1'b0);
    beat(32'hE8EEF0FA, 32'h02020202, 1'b1);
    @(posedge clk); #1;
    hold_rns = out_rns; hold_cnt = out_count;
    chk("t3_rns", out_rns, 32'hE5EBEDF7);
    chk("t3_cnt", 32'(out_count), 32'd2);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("bp_ov", 32'(out_valid), 32'd1);
      chk("bp_in_ready", 32'(in_ready), 32'd0);
      chk("bp_rns_stable", out_rns, 32'hE5EBEDF7);
      chk("bp_cnt_stable", 32'(out_count), 32'd2);
    end
    @(negedge clk); out_ready = 1'b1;
    @(posedge clk); #1; out_ready = 1'b0;
    chk("bp_ov_drop", 32'(out_valid), 32'd0);
    chk("bp_in_ready_back", 32'(in_ready), 32'd1);
    chk("bp_rns_kept", out_rns, hold_rns);
    chk("bp_cnt_kept", 32'(out_count), 32'(hold_cnt));

    // async reset between edges mid-vector
    beat(32'h01010101, 32'h01010101, 1'b0);
    beat(32'h02020202, 32'h01010101, 1'b0);
    #2 rst = 1'b1;
    #1;
    chk("mrst_out_rns", out_rns, 32'd0);
    chk("mrst_out_count", 32'(out_count), 32'd0);
    chk("mrst_busy", 32'(busy), 32'd0);
    chk("mrst_in_ready", 32'(in_ready), 32'd1);
    chk("mrst_ov", 32'(out_valid), 32'd0);
    #1 rst = 1'b0;

    // single-beat vector with out_ready already high: one out_valid cycle
    out_ready = 1'b1;
    beat(32'h03030303, 32'h05050505, 1'b1);
    chk("sb_ov_early", 32'(out_valid), 32'd0);
    @(posedge clk); #1;
    chk("sb_ov", 32'(out_valid), 32'd1);
    chk("sb_rns", out_rns, 32'h0F0F0F0F);
    chk("sb_cnt", 32'(out_count), 32'd1);
    @(posedge clk); #1;
    chk("sb_ov_one_cycle", 32'(out_valid), 32'd0);
    chk("sb_in_ready", 32'(in_ready), 32'd1);
    out_ready = 1'b0;

    // random stream against a per-channel reference model
    beats = 0;
    while (beats < 1000) begin
      vlen = $urandom_range(1, 8);
      if (beats + vlen > 1000) vlen = 1000 - beats;
      for (int c = 0; c < 4; c++) acc[c] = 0;
      for (nb = 0; nb < vlen; nb++) begin
        for (int c = 0; c < 4; c++) begin
          ra[8*c +: 8] = 8'($urandom_range(0, MODS[c] - 1));
          rb[8*c +: 8] = 8'($urandom_range(0, MODS[c] - 1));
          acc[c] = (acc[c] + (int'(ra[8*c +: 8]) * int'(rb[8*c +: 8])) % MODS[c]) % MODS[c];
        end
        repeat ($urandom_range(0, 2)) @(negedge clk);
        beat(ra, rb, (nb == vlen - 1) ? 1'b1 : 1'b0);
      end
      beats += vlen;
      take("rnd", {8'(acc[3]), 8'(acc[2]), 8'(acc[1]), 8'(acc[0])}, vlen, $urandom_range(0, 3));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
